// File: rtl/boot_mem_arbiter.sv
// +----------------------------------------------------------------------------+
// | boot_mem_arbiter                                                           |
// | Shares the single-port boot RAM between CPU fetches (absolute priority)    |
// | and a framed MCU load stream; decodes MCU commands and drives boot_on.     |
// | Optional feature: BOOT_CSUM_EN adds a csum output (XOR of committed bytes).|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module boot_mem_arbiter #(
    parameter int AW          = 10,    // RAM address width, 9..16
    parameter bit BOOT_ON_RST = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_rd,
    input  logic [AW-1:0] cpu_addr,
    output logic [7:0]    cpu_dat,
    output logic          cpu_dat_vld,
    input  logic          mcu_frame,
    input  logic [7:0]    mcu_byte,
    input  logic          mcu_byte_vld,
    output logic          mcu_byte_rdy,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [7:0]    ram_wdat,
    input  logic [7:0]    ram_rdat,
    output logic          boot_on
`ifdef BOOT_CSUM_EN
    ,
    output logic [7:0]    csum
`endif
);

    localparam logic [7:0]    C_CMD_ADDR  = 8'h01;
    localparam logic [7:0]    C_CMD_WRITE = 8'h02;
    localparam logic [7:0]    C_CMD_BOOT  = 8'h03;
    localparam logic [AW-1:0] C_PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR_LO = 3'd1,
        S_ADDR_HI = 3'd2,
        S_WRDATA  = 3'd3,
        S_BOOTCFG = 3'd4,
        S_DISCARD = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_rd_meta;
    logic            r_rd_s;
    logic [AW-1:0]   r_addr_meta;
    logic [AW-1:0]   r_addr_s;

    logic            r_rd_prev;
    logic [AW-1:0]   r_addr_prev;
    logic            r_vld;
    logic [7:0]      r_cpu_dat;
    logic            w_addr_same;

    logic [AW-1:0]   r_ptr;
    logic            r_wbuf_vld;
    logic [AW-1:0]   r_wbuf_addr;
    logic [7:0]      r_wbuf_dat;
    logic            r_boot_on;

    logic            w_drain;
    logic            w_take;
    logic            w_load;

    // cpu_rd is asynchronous; the address travels through the same two stages
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_meta   <= 1'b0;
            r_rd_s      <= 1'b0;
            r_addr_meta <= '0;
            r_addr_s    <= '0;
        end else begin
            r_rd_meta   <= cpu_rd;
            r_rd_s      <= r_rd_meta;
            r_addr_meta <= cpu_addr;
            r_addr_s    <= r_addr_meta;
        end
    end

    assign w_addr_same = (r_addr_s == r_addr_prev);

    // Data is captured on the second cycle an address is held; valid is
    // masked combinationally so an address change or read drop clears it at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_prev   <= 1'b0;
            r_addr_prev <= '0;
            r_vld       <= 1'b0;
            r_cpu_dat   <= 8'h00;
        end else begin
            r_rd_prev   <= r_rd_s;
            r_addr_prev <= r_addr_s;
            if (r_rd_s && r_rd_prev && w_addr_same) begin
                r_cpu_dat <= ram_rdat;
                r_vld     <= 1'b1;
            end else begin
                r_vld     <= 1'b0;
            end
        end
    end

    assign cpu_dat     = r_cpu_dat;
    assign cpu_dat_vld = r_vld & r_rd_s & w_addr_same;

    assign w_drain  = r_wbuf_vld & ~r_rd_s;
    assign ram_addr = r_rd_s ? r_addr_s : r_wbuf_addr;
    assign ram_we   = w_drain;
    assign ram_wdat = r_wbuf_dat;

    // No bytes are accepted outside an open frame (also keeps rdy low after reset)
    assign mcu_byte_rdy = mcu_frame & ((r_state != S_WRDATA) | ~r_wbuf_vld | ~r_rd_s);
    assign w_take       = mcu_byte_vld & mcu_byte_rdy;
    assign w_load       = w_take & (r_state == S_WRDATA);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!mcu_frame) begin
            w_state_nxt = S_IDLE;
        end else if (w_take) begin
            case (r_state)
                S_IDLE: begin
                    case (mcu_byte)
                        C_CMD_ADDR:  w_state_nxt = S_ADDR_LO;
                        C_CMD_WRITE: w_state_nxt = S_WRDATA;
                        C_CMD_BOOT:  w_state_nxt = S_BOOTCFG;
                        default:     w_state_nxt = S_DISCARD;
                    endcase
                end
                S_ADDR_LO: w_state_nxt = S_ADDR_HI;
                S_ADDR_HI: w_state_nxt = S_IDLE;
                S_WRDATA:  w_state_nxt = S_WRDATA;
                S_BOOTCFG: w_state_nxt = S_DISCARD;
                default:   w_state_nxt = S_DISCARD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_wbuf_vld  <= 1'b0;
            r_wbuf_addr <= '0;
            r_wbuf_dat  <= 8'h00;
            r_boot_on   <= BOOT_ON_RST;
        end else begin
            // load wins over drain: a same-cycle drain frees the slot being refilled
            if (w_load) begin
                r_wbuf_vld  <= 1'b1;
                r_wbuf_addr <= r_ptr;
                r_wbuf_dat  <= mcu_byte;
                r_ptr       <= r_ptr + C_PTR_ONE;
            end else if (w_drain) begin
                r_wbuf_vld  <= 1'b0;
            end
            if (w_take && r_state == S_ADDR_LO) begin
                r_ptr[7:0] <= mcu_byte;
            end
            if (w_take && r_state == S_ADDR_HI) begin
                r_ptr[AW-1:8] <= mcu_byte[AW-9:0];
            end
            if (w_take && r_state == S_BOOTCFG) begin
                r_boot_on <= mcu_byte[0];
            end
        end
    end

    assign boot_on = r_boot_on;

`ifdef BOOT_CSUM_EN
    logic [7:0] r_csum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_csum <= 8'h00;
        end else if (w_take && r_state == S_IDLE && mcu_byte == C_CMD_WRITE) begin
            r_csum <= 8'h00;
        end else if (w_drain) begin
            r_csum <= r_csum ^ r_wbuf_dat;
        end
    end

    assign csum = r_csum;
`endif

endmodule

`default_nettype wire
